// File: rtl/pinball_pkg.sv
// Shared key-decoder types and the scan codes used by the pinball front end.
// Codes are 9 bits wide; bit 8 is set for E0-extended scan codes.
package pinball_pkg;

  localparam int KEY_CODE_W = 9;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  localparam key_code_t KEY_LEFT  = 9'h16B;
  localparam key_code_t KEY_RIGHT = 9'h174;
  localparam key_code_t KEY_SPACE = 9'h029;
  localparam key_code_t KEY_ENTER = 9'h05A;

  typedef enum logic {
    KEY_IDLE = 1'b0,
    KEY_HELD = 1'b1
  } key_state_t;

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One decoded key: IDLE/HELD state machine, auto-repeat countdown and toggle latch.
// Every output is taken straight from a flop, so it changes one cycle after the qualifying input.
module key_channel
  import pinball_pkg::*;
#(
  parameter int CNT_W         = 3,
  parameter int HOLD_DELAY    = 4,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic make_hit,
  input  logic break_hit,
  input  logic clear_latch,
  output logic pressed,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic latch,
  output logic strobe
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             strobe_q, strobe_d;
  logic             latch_q, latch_d;
  logic             press_s;

  // A break always overrides a make in the same cycle.
  assign press_s = make_hit & ~break_hit;

  // State, counter and output flops.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= KEY_IDLE;
      cnt_q    <= CNT_ZERO;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      strobe_q <= 1'b0;
      latch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      strobe_q <= strobe_d;
      latch_q  <= latch_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      KEY_IDLE: begin
        if (press_s) state_d = KEY_HELD;
        else         state_d = KEY_IDLE;
      end
      KEY_HELD: begin
        if (break_hit) state_d = KEY_IDLE;
        else           state_d = KEY_HELD;
      end
      default: state_d = KEY_IDLE;
    endcase
  end

  // Pulses, repeat counter and latch; typematic re-makes while held are ignored.
  always_comb begin
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    strobe_d = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      KEY_IDLE: begin
        if (press_s) begin
          rise_d   = 1'b1;
          strobe_d = 1'b1;
          cnt_d    = HOLD_LOAD;
        end else begin
          cnt_d    = CNT_ZERO;
        end
      end
      KEY_HELD: begin
        if (break_hit) begin
          fall_d = 1'b1;
          cnt_d  = CNT_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          strobe_d = 1'b1;
          cnt_d    = REP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase

    if (clear_latch)  latch_d = 1'b0;
    else if (rise_d)  latch_d = ~latch_q;
    else              latch_d = latch_q;
  end

  assign pressed    = (state_q == KEY_HELD);
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign strobe     = strobe_q;
  assign latch      = latch_q;

endmodule

// File: rtl/key_decoder_bank.sv
// N-channel PS/2 key decoder: matches the incoming scan code against each channel's code
// and feeds one key_channel per key; also registers an any-key-held flag.
module key_decoder_bank
  import pinball_pkg::*;
#(
  parameter int        NUM_KEYS                = 4,
  parameter key_code_t KEY_CODES [NUM_KEYS]    = '{KEY_LEFT, KEY_RIGHT, KEY_SPACE, KEY_ENTER},
  parameter int        HOLD_DELAY              = 12_500_000,
  parameter int        REPEAT_PERIOD           = 2_500_000
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [8:0]          key_code,
  input  logic                make,
  input  logic                breakk,
  input  logic                clearLatch,
  output logic [NUM_KEYS-1:0] keyIsPressed,
  output logic [NUM_KEYS-1:0] keyRisingEdgePulse,
  output logic [NUM_KEYS-1:0] keyFallingEdgePulse,
  output logic [NUM_KEYS-1:0] keyLatch,
  output logic [NUM_KEYS-1:0] keyStrobe,
  output logic                anyKeyPressed
);

  localparam int CNT_W = $clog2(max_int(HOLD_DELAY, REPEAT_PERIOD)) + 1;

  logic [NUM_KEYS-1:0] make_hit_s;
  logic [NUM_KEYS-1:0] break_hit_s;
  logic                any_q, any_d;

  // Duplicate codes simply light up every channel that carries them.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    assign make_hit_s[i]  = make   & (key_code == KEY_CODES[i]);
    assign break_hit_s[i] = breakk & (key_code == KEY_CODES[i]);

    key_channel #(
      .CNT_W         (CNT_W),
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk         (clk),
      .resetN      (resetN),
      .make_hit    (make_hit_s[i]),
      .break_hit   (break_hit_s[i]),
      .clear_latch (clearLatch),
      .pressed     (keyIsPressed[i]),
      .rise_pulse  (keyRisingEdgePulse[i]),
      .fall_pulse  (keyFallingEdgePulse[i]),
      .latch       (keyLatch[i]),
      .strobe      (keyStrobe[i])
    );
  end

  // Reduction of the registered press levels, so it trails keyIsPressed by a cycle.
  always_comb begin
    any_d = |keyIsPressed;
  end

  // Any-key flop.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) any_q <= 1'b0;
    else         any_q <= any_d;
  end

  assign anyKeyPressed = any_q;

endmodule

// File: tb/tb_key_decoder_bank.sv
// Directed scenarios followed by random key traffic, checked against a cycle-indexed reference
// model that schedules repeat strobes as absolute cycle numbers.
module tb_key_decoder_bank;

  localparam int NK = 4;
  localparam int HD = 4;
  localparam int RP = 2;

  logic          clk = 1'b0;
  logic          resetN;
  logic [8:0]    key_code;
  logic          make;
  logic          breakk;
  logic          clearLatch;
  logic [NK-1:0] keyIsPressed;
  logic [NK-1:0] keyRisingEdgePulse;
  logic [NK-1:0] keyFallingEdgePulse;
  logic [NK-1:0] keyLatch;
  logic [NK-1:0] keyStrobe;
  logic          anyKeyPressed;

  logic [8:0] codes [NK] = '{9'h16B, 9'h174, 9'h029, 9'h05A};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit            m_held  [NK];
  bit            m_latch [NK];
  int            m_next  [NK];
  logic [NK-1:0] e_p, e_r, e_f, e_l, e_s;
  logic          e_any;

  always #5 clk = ~clk;

  key_decoder_bank #(
    .NUM_KEYS      (NK),
    .KEY_CODES     ('{9'h16B, 9'h174, 9'h029, 9'h05A}),
    .HOLD_DELAY    (HD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .key_code            (key_code),
    .make                (make),
    .breakk              (breakk),
    .clearLatch          (clearLatch),
    .keyIsPressed        (keyIsPressed),
    .keyRisingEdgePulse  (keyRisingEdgePulse),
    .keyFallingEdgePulse (keyFallingEdgePulse),
    .keyLatch            (keyLatch),
    .keyStrobe           (keyStrobe),
    .anyKeyPressed       (anyKeyPressed)
  );

  task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_held[i]  = 1'b0;
      m_latch[i] = 1'b0;
      m_next[i]  = 0;
    end
    e_p = '0; e_r = '0; e_f = '0; e_l = '0; e_s = '0; e_any = 1'b0;
  endtask

  // Expected outputs visible in cycle cyc+1 given the inputs applied during cycle cyc.
  task automatic model_step(input logic mk, input logic br, input logic [8:0] code, input logic clr);
    e_any = 1'b0;
    for (int i = 0; i < NK; i++) e_any = e_any | m_held[i];
    for (int i = 0; i < NK; i++) begin
      bit hit;
      hit = (code == codes[i]);
      e_r[i] = 1'b0; e_f[i] = 1'b0; e_s[i] = 1'b0;
      if (br && hit) begin
        if (m_held[i]) e_f[i] = 1'b1;
        m_held[i] = 1'b0;
      end else if (mk && hit && !m_held[i]) begin
        m_held[i]  = 1'b1;
        e_r[i]     = 1'b1;
        e_s[i]     = 1'b1;
        m_latch[i] = ~m_latch[i];
        m_next[i]  = cyc + 1 + HD;
      end else if (m_held[i] && (cyc + 1 == m_next[i])) begin
        e_s[i]    = 1'b1;
        m_next[i] = m_next[i] + RP;
      end
      if (clr) m_latch[i] = 1'b0;
      e_p[i] = m_held[i];
      e_l[i] = m_latch[i];
    end
  endtask

  task automatic cycle(input logic mk, input logic br, input logic [8:0] code, input logic clr);
    make = mk; breakk = br; key_code = code; clearLatch = clr;
    model_step(mk, br, code, clr);
    @(posedge clk);
    #1;
    check("pressed", keyIsPressed, e_p);
    check("rise", keyRisingEdgePulse, e_r);
    check("fall", keyFallingEdgePulse, e_f);
    check("latch", keyLatch, e_l);
    check("strobe", keyStrobe, e_s);
    check("any", {3'b000, anyKeyPressed}, {3'b000, e_any});
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 9'h000, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pressed"}, keyIsPressed, 4'b0000);
    check({tag, "_rise"}, keyRisingEdgePulse, 4'b0000);
    check({tag, "_fall"}, keyFallingEdgePulse, 4'b0000);
    check({tag, "_latch"}, keyLatch, 4'b0000);
    check({tag, "_strobe"}, keyStrobe, 4'b0000);
    check({tag, "_any"}, {3'b000, anyKeyPressed}, 4'b0000);
  endtask

  initial begin
    resetN = 1'b0; make = 1'b0; breakk = 1'b0; clearLatch = 1'b0; key_code = 9'h000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetN = 1'b1;

    // Press LEFT at cycle 10, typematic re-make at 13, unextended 06B at 14, release at 20.
    while (cyc < 10) idle();
    cycle(1'b1, 1'b0, 9'h16B, 1'b0);
    check("t1_pressed", keyIsPressed, 4'b0001);
    check("t1_rise", keyRisingEdgePulse, 4'b0001);
    check("t1_strobe", keyStrobe, 4'b0001);
    check("t1_latch", keyLatch, 4'b0001);
    idle(); idle();
    cycle(1'b1, 1'b0, 9'h16B, 1'b0);
    check("t3_no_rise", keyRisingEdgePulse, 4'b0000);
    cycle(1'b1, 1'b0, 9'h06B, 1'b0);
    check("t2_strobe15", keyStrobe, 4'b0001);
    while (cyc < 20) idle();
    cycle(1'b0, 1'b1, 9'h16B, 1'b0);
    check("t2_fall", keyFallingEdgePulse, 4'b0001);
    check("t2_released", keyIsPressed, 4'b0000);
    repeat (6) idle();

    // Simultaneous make and break on RIGHT, idle then held.
    cycle(1'b1, 1'b1, 9'h174, 1'b0);
    check("t4_idle_nochange", keyIsPressed, 4'b0000);
    cycle(1'b1, 1'b0, 9'h174, 1'b0);
    idle();
    cycle(1'b1, 1'b1, 9'h174, 1'b0);
    check("t4_held_fall", keyFallingEdgePulse, 4'b0010);
    idle();

    // Latch toggling on ENTER and clear coinciding with a press.
    cycle(1'b1, 1'b0, 9'h05A, 1'b0);
    check("t5_latch1", keyLatch[3:0], 4'b1010 & 4'b1000 | (keyLatch & 4'b0111));
    cycle(1'b0, 1'b1, 9'h05A, 1'b0);
    cycle(1'b1, 1'b0, 9'h05A, 1'b0);
    check("t5_latch0", {3'b000, keyLatch[3]}, 4'b0000);
    cycle(1'b0, 1'b1, 9'h05A, 1'b0);
    cycle(1'b1, 1'b0, 9'h05A, 1'b1);
    check("t5_clear_wins", {3'b000, keyLatch[3]}, 4'b0000);
    check("t5_clear_rise", keyRisingEdgePulse, 4'b1000);
    cycle(1'b0, 1'b1, 9'h05A, 1'b0);

    // Reset in the middle of holding LEFT and SPACE.
    cycle(1'b1, 1'b0, 9'h16B, 1'b0);
    cycle(1'b1, 1'b0, 9'h029, 1'b0);
    idle(); idle();
    make = 1'b0; breakk = 1'b0; clearLatch = 1'b0;
    resetN = 1'b0;
    #1;
    check_all_zero("t6_async");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("t6_held");
    resetN = 1'b1;
    cyc++;
    repeat (8) idle();
    check("t6_no_fall", keyFallingEdgePulse, 4'b0000);
    check("t6_any", {3'b000, anyKeyPressed}, 4'b0000);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int          r;
      logic [8:0]  c;
      r = $urandom_range(0, 5);
      if (r < NK)      c = codes[r];
      else if (r == 4) c = 9'h06B;
      else             c = 9'($urandom_range(0, 511));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, c, $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
